// File: rtl/i2c_tx_fifo.sv
// Transmit command FIFO for the I2C master (first-word-fall-through).
// Each entry: bit 9 STOP, bit 8 START/repeated-START, bits 7:0 payload.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   soft_rst          synchronous flush; overrides wr_en/rd_en/clr_err
//   wr_en, din        write strobe and command word
//   rd_en             pop strobe from the byte engine
//   dout              head entry, valid when empty=0 (0 when empty)
//   empty, full, occ  occupancy status (registered)
//   half_empty        occ <= DEPTH/2 (registered)
//   overflow          sticky: write attempted while full without a pop
//   underflow         sticky: pop attempted while empty
//   clr_err           clears both sticky flags (a new error the same cycle wins)
module i2c_tx_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          soft_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   occ,
  output logic          half_empty,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_HALF = (AW+1)'(DEPTH / 2);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          half_empty_q, half_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Accept strobes; a pop frees a slot, so a full FIFO still takes a write
  // alongside a pop.
  always_comb begin
    rd_acc = rd_en & ~empty_q & ~soft_rst;
    wr_acc = wr_en & (~full_q | rd_acc) & ~soft_rst;
  end

  // Next-state for pointers, occupancy, status and sticky errors.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    occ_d        = occ_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (soft_rst) begin
      wptr_d      = '0;
      rptr_d      = '0;
      occ_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);
      occ_d = occ_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      // Set has priority over clear.
      overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full_q & ~rd_acc);
      underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_q);
    end

    empty_d      = (occ_d == '0);
    full_d       = (occ_d == OCC_FULL);
    half_empty_d = (occ_d <= OCC_HALF);
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      half_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      half_empty_q <= half_empty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array; contents need no reset since dout is gated by occupancy.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= din;
  end

  // FWFT head: combinational from registered state only.
  always_comb begin
    dout       = (occ_q != '0) ? mem_q[rptr_q] : '0;
    empty      = empty_q;
    full       = full_q;
    occ        = occ_q;
    half_empty = half_empty_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
  end

endmodule
